// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter with a one-entry holding buffer.
//
// A word is accepted on any clk edge with tx_valid && tx_ready and parked in
// the holding buffer. The frame engine pulls it into the shift register when
// idle, or straight from the final stop-bit cycle of the previous frame, so
// back-to-back words leave with no idle gap between frames.
//
// Frame: start (0), DATA_BITS data bits LSB first, optional parity bit,
// STOP_BITS stop bits (1). Every bit lasts CLKS_PER_BIT clk cycles.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-low reset
//   tx_valid   tx_data is valid for transfer
//   tx_data    word to send, sampled only at the handshake edge
//   tx_ready   holding buffer empty
//   txd        registered serial output, idles high
//   busy       a frame is in progress
//   frame_done one-cycle pulse during the final stop-bit cycle
module uart_tx_cfg #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 busy,
    output logic                 frame_done
);

    // Reject illegal configurations at elaboration time.
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
        $error("uart_tx_cfg: CLKS_PER_BIT must be in 2..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end
    if (PARITY_MODE > 2) begin : g_bad_parity_mode
        $error("uart_tx_cfg: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    localparam int unsigned     BaudW     = $clog2(CLKS_PER_BIT);
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      DataLast  = 4'(DATA_BITS - 1);
    localparam logic [3:0]      StopLast  = 4'(STOP_BITS - 1);
    localparam bit              HasParity = (PARITY_MODE != 0);
    localparam bit              OddParity = (PARITY_MODE == 2);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                 state_q, state_d;
    logic [BaudW-1:0]       baud_q, baud_d;
    logic [3:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   parity_q, parity_d;
    logic [DATA_BITS-1:0]   buf_q, buf_d;
    logic                   buf_full_q, buf_full_d;
    logic                   txd_q, txd_d;

    logic bit_end;
    logic last_stop;
    logic load;
    logic accept;

    assign bit_end   = (baud_q == BaudLast);
    assign last_stop = (state_q == StStop) && bit_end && (bit_q == StopLast);
    assign accept    = tx_valid && !buf_full_q;

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q + BaudW'(1);
        bit_d      = bit_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        txd_d      = txd_q;
        load       = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Baud counter held at zero so bit timing starts with the frame.
                baud_d = '0;
                txd_d  = 1'b1;
                if (buf_full_q) begin
                    load = 1'b1;
                end
            end

            StStart: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StData;
                    txd_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end

            StData: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == DataLast) begin
                        bit_d = '0;
                        if (HasParity) begin
                            state_d = StParity;
                            txd_d   = parity_q;
                        end else begin
                            state_d = StStop;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        txd_d   = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end

            StParity: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StStop;
                    txd_d   = 1'b1;
                end
            end

            StStop: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == StopLast) begin
                        // A buffered word chains straight into the next start bit.
                        if (buf_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = StIdle;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end

            default: begin
                state_d = StIdle;
                txd_d   = 1'b1;
            end
        endcase

        if (load) begin
            state_d    = StStart;
            baud_d     = '0;
            bit_d      = '0;
            shift_d    = buf_q;
            parity_d   = (^buf_q) ^ OddParity;
            buf_full_d = 1'b0;
            txd_d      = 1'b0;
        end

        // load needs a full buffer and accept needs an empty one, so these never
        // collide on the same edge.
        if (accept) begin
            buf_d      = tx_data;
            buf_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            txd_q      <= txd_d;
        end
    end

    assign txd        = txd_q;
    assign tx_ready   = !buf_full_q;
    assign busy       = (state_q != StIdle);
    assign frame_done = last_stop;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four instances (8N1, 8E1, 8O1, 7N2, all 4 clk/bit)
// checked every cycle against a frame-level model, plus literal waveform
// checks and a serial decoder on the 8N1 line.
module tb_uart_tx_cfg;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] valid = 4'b0;
    logic [8:0] data [4];
    wire  [3:0] ready;
    wire  [3:0] txd;
    wire  [3:0] busy;
    wire  [3:0] fd;

    int nvec = 0;
    int nerr = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .reset(reset), .tx_valid(valid[0]), .tx_data(data[0][7:0]),
        .tx_ready(ready[0]), .txd(txd[0]), .busy(busy[0]), .frame_done(fd[0]));
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .reset(reset), .tx_valid(valid[1]), .tx_data(data[1][7:0]),
        .tx_ready(ready[1]), .txd(txd[1]), .busy(busy[1]), .frame_done(fd[1]));
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .reset(reset), .tx_valid(valid[2]), .tx_data(data[2][7:0]),
        .tx_ready(ready[2]), .txd(txd[2]), .busy(busy[2]), .frame_done(fd[2]));
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .reset(reset), .tx_valid(valid[3]), .tx_data(data[3][6:0]),
        .tx_ready(ready[3]), .txd(txd[3]), .busy(busy[3]), .frame_done(fd[3]));

    // ---------------- frame-level model ----------------
    function automatic int db_of(input int k);
        return (k == 3) ? 7 : 8;
    endfunction
    function automatic int pm_of(input int k);
        return (k == 1) ? 1 : (k == 2) ? 2 : 0;
    endfunction
    function automatic int sb_of(input int k);
        return (k == 3) ? 2 : 1;
    endfunction
    function automatic int flen(input int k);
        return (1 + db_of(k) + ((pm_of(k) != 0) ? 1 : 0) + sb_of(k)) * 4;
    endfunction

    // Line level at cycle pos (0-based) of a frame carrying word w.
    function automatic logic bitval(input int k, input logic [8:0] w, input int pos);
        int   idx;
        logic p;
        idx = pos / 4;
        p   = 1'b0;
        for (int i = 0; i < db_of(k); i++) p = p ^ w[i];
        if (idx == 0) return 1'b0;
        if (idx <= db_of(k)) return w[idx-1];
        if (pm_of(k) != 0 && idx == db_of(k) + 1) return (pm_of(k) == 1) ? p : ~p;
        return 1'b1;
    endfunction

    int         rem [4];   // cycles of the current frame still to show, 0 = idle
    logic [8:0] cur [4];
    logic [8:0] bufw [4];
    bit         full [4];

    initial begin
        for (int k = 0; k < 4; k++) begin
            rem[k] = 0; full[k] = 1'b0; cur[k] = '0; bufw[k] = '0; data[k] = '0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!reset) begin
                rem[k]  = 0;
                full[k] = 1'b0;
            end else begin
                bit old_full;
                old_full = full[k];
                if (rem[k] > 0) rem[k]--;
                if (rem[k] == 0 && old_full) begin
                    cur[k]  = bufw[k];
                    rem[k]  = flen(k);
                    full[k] = 1'b0;
                end
                if (valid[k] && !old_full) begin
                    bufw[k] = data[k];
                    full[k] = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 4; k++) begin
                logic et;
                et = (rem[k] == 0) ? 1'b1 : bitval(k, cur[k], flen(k) - rem[k]);
                chk($sformatf("txd%0d", k), 9'(txd[k]), 9'(et));
                chk($sformatf("busy%0d", k), 9'(busy[k]), 9'(rem[k] > 0));
                chk($sformatf("frame_done%0d", k), 9'(fd[k]), 9'(rem[k] == 1));
                chk($sformatf("tx_ready%0d", k), 9'(ready[k]), 9'(!full[k]));
            end
        end
    end

    // ---------------- serial decoder on the 8N1 line ----------------
    bit         rx_act = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_word;
    logic [7:0] rx_q [$];

    always @(negedge clk) begin
        if (!reset) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (txd[0] === 1'b0) begin
                rx_act = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % 4) == 2) rx_word[(rx_cnt-6)/4] = txd[0];
            if (rx_cnt == 38) begin
                rx_q.push_back(rx_word);
                rx_act = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Offer w on instance k and return 2 time units after the transfer edge,
    // with tx_valid still high.
    task automatic send(input int k, input logic [8:0] w);
        int n;
        valid[k] = 1'b1;
        data[k]  = w;
        n = 0;
        while (ready[k] !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        if (n >= 200) chk($sformatf("send%0d_timeout", k), 9'd0, 9'd1);
        tick(1);
    endtask

    task automatic wait_fd0();
        int n;
        n = 0;
        while (fd[0] !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        if (n >= 200) chk("wait_frame_done_timeout", 9'd0, 9'd1);
    endtask

    logic lt [4][48];
    logic lb [4][48];
    logic lf [4][48];
    logic a5_bits [8];

    initial begin
        #6 chk_en = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(2);

        // Single frame on all four configurations at once.
        data[0] = 9'h0A5; data[1] = 9'h007; data[2] = 9'h007; data[3] = 9'h07F;
        valid = 4'hF;
        tick(1);
        valid = 4'h0;
        for (int c = 0; c < 48; c++) begin
            for (int k = 0; k < 4; k++) begin
                lt[k][c] = txd[k]; lb[k][c] = busy[k]; lf[k][c] = fd[k];
            end
            tick(1);
        end
        a5_bits = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int c = 0; c < 42; c++) begin
            logic e;
            e = (c == 0) ? 1'b1 : (c <= 4) ? 1'b0 : (c <= 36) ? a5_bits[(c-5)/4] : 1'b1;
            chk($sformatf("lit_8n1_txd_c%0d", c), 9'(lt[0][c]), 9'(e));
        end
        chk("lit_8n1_busy_c0", 9'(lb[0][0]), 9'd0);
        chk("lit_8n1_busy_c1", 9'(lb[0][1]), 9'd1);
        chk("lit_8n1_busy_c40", 9'(lb[0][40]), 9'd1);
        chk("lit_8n1_busy_c41", 9'(lb[0][41]), 9'd0);
        chk("lit_8n1_fd_c39", 9'(lf[0][39]), 9'd0);
        chk("lit_8n1_fd_c40", 9'(lf[0][40]), 9'd1);
        chk("lit_8n1_fd_c41", 9'(lf[0][41]), 9'd0);
        chk("lit_8e1_parity", 9'(lt[1][39]), 9'd1);
        chk("lit_8e1_fd_c44", 9'(lf[1][44]), 9'd1);
        chk("lit_8o1_parity", 9'(lt[2][39]), 9'd0);
        chk("lit_7n2_data6", 9'(lt[3][31]), 9'd1);
        chk("lit_7n2_stop1", 9'(lt[3][34]), 9'd1);
        chk("lit_7n2_stop2", 9'(lt[3][38]), 9'd1);
        chk("lit_7n2_fd_c40", 9'(lf[3][40]), 9'd1);
        chk("lit_7n2_busy_c41", 9'(lb[3][41]), 9'd0);
        chk("lit_8n1_rx_a5", 9'(rx_q.size() == 1 ? rx_q[0] : 8'h00), 9'h0A5);

        // Back-to-back: second word chains with no idle cycle.
        rx_q.delete();
        send(0, 9'h011);
        send(0, 9'h022);
        valid[0] = 1'b0;
        chk("b2b_ready_low", 9'(ready[0]), 9'd0);
        wait_fd0();
        chk("b2b_last_stop_high", 9'(txd[0]), 9'd1);
        tick(1);
        chk("b2b_start_next", 9'(txd[0]), 9'd0);
        chk("b2b_busy_next", 9'(busy[0]), 9'd1);
        tick(45);
        chk("b2b_rx_count", 9'(rx_q.size()), 9'd2);
        if (rx_q.size() == 2) begin
            chk("b2b_rx0", 9'(rx_q[0]), 9'h011);
            chk("b2b_rx1", 9'(rx_q[1]), 9'h022);
        end

        // Backpressure: three words offered continuously.
        rx_q.delete();
        send(0, 9'h011);
        send(0, 9'h022);
        send(0, 9'h033);
        valid[0] = 1'b0;
        tick(130);
        chk("bp_rx_count", 9'(rx_q.size()), 9'd3);
        if (rx_q.size() == 3) begin
            chk("bp_rx0", 9'(rx_q[0]), 9'h011);
            chk("bp_rx1", 9'(rx_q[1]), 9'h022);
            chk("bp_rx2", 9'(rx_q[2]), 9'h033);
        end

        // Mid-frame reset during data bit 3, with a second word buffered.
        rx_q.delete();
        send(0, 9'h03C);
        send(0, 9'h055);
        valid[0] = 1'b0;
        tick(15);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        chk("rst_txd", 9'(txd[0]), 9'd1);
        chk("rst_busy", 9'(busy[0]), 9'd0);
        chk("rst_ready", 9'(ready[0]), 9'd1);
        tick(3);
        chk("rst_buffer_dropped", 9'(busy[0]), 9'd0);
        send(0, 9'h096);
        valid[0] = 1'b0;
        tick(45);
        chk("rst_rx_count", 9'(rx_q.size()), 9'd1);
        if (rx_q.size() == 1) chk("rst_rx0", 9'(rx_q[0]), 9'h096);

        // Transfer on the frame_done edge with an empty buffer.
        send(0, 9'h05A);
        valid[0] = 1'b0;
        wait_fd0();
        chk("col_ready_at_fd", 9'(ready[0]), 9'd1);
        valid[0] = 1'b1;
        data[0]  = 9'h0C3;
        tick(1);
        valid[0] = 1'b0;
        chk("col_idle_txd", 9'(txd[0]), 9'd1);
        chk("col_idle_busy", 9'(busy[0]), 9'd0);
        chk("col_idle_ready", 9'(ready[0]), 9'd0);
        tick(1);
        chk("col_start_txd", 9'(txd[0]), 9'd0);
        chk("col_start_busy", 9'(busy[0]), 9'd1);
        tick(45);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter. It is the successor to the fixed 8N1 transmitter (load pulse, baud-rate enable, tx FSM).
- Supports configurable data width, parity mode, stop-bit count and baud divisor.
- Uses a valid/ready handshake with a one-entry holding buffer, so back-to-back frames go out with no idle gap.
- Sits between the system-side byte source and the serial pin.

Parameters:
CLKS_PER_BIT, 5208, clock cycles per serial bit. Legal range 2..65535. The default gives 50 MHz / 9600 baud.
DATA_BITS, 8, data bits per frame. Legal range 5..9.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, number of stop bits. Legal values 1 or 2.
Out-of-range values must fail elaboration.

Ports:
clk  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk
tx_valid  input  1  tx_data is valid for transfer
tx_data  input  DATA_BITS  word to send; sampled only at handshake
tx_ready  output  1  holding buffer empty; a word can be accepted
txd  output  1  serial line; idles high
busy  output  1  a frame is in progress (FSM not IDLE)
frame_done  output  1  one-cycle pulse at the end of the final stop bit

Behaviour:
- Reset (reset==0 at a clk edge):
  - txd=1, tx_ready=1, busy=0, frame_done=0.
  - Buffer empty, FSM=IDLE, baud and bit counters 0.
  - Applies mid-frame: the frame is aborted, txd is 1 after that edge, and the buffered word is discarded.
- Handshake:
  - Transfer occurs on an edge with tx_valid && tx_ready. tx_data is copied into the holding buffer and tx_ready drops after that edge.
  - tx_valid with tx_ready low has no effect. The source keeps tx_valid and tx_data until transfer.
- Frame format: start bit (0), then DATA_BITS data bits LSB first, then an optional parity bit, then STOP_BITS stop bits (1).
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - Frame length = (1 + DATA_BITS + (PARITY_MODE!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
- Parity:
  - Even: parity bit = XOR of the data bits.
  - Odd: parity bit = the inverse of that XOR.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: txd=1. If the buffer is full at the edge, move to START on that edge. The shift register loads from the buffer, the buffer empties (tx_ready=1 after the edge), and txd=0.
  - The start bit therefore appears one cycle after the transfer edge when the FSM was idle.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA: shift right once per bit period. After DATA_BITS bits, go to PARITY (PARITY_MODE!=0) or STOP.
  - PARITY -> STOP after one bit period.
  - STOP: lasts STOP_BITS bit periods. On the final cycle, frame_done=1 for one cycle. Then:
    - buffer full at that edge: go directly to START (no idle cycle) and load the next word;
    - otherwise: go to IDLE.
- Simultaneous events:
  - A transfer on the same edge that ends a frame with an empty buffer gives exactly one IDLE cycle (txd=1) before START.
  - While a frame is in progress, the buffer accepts one word. tx_ready then stays low until that word is loaded into the shift register.
- Baud counter:
  - Width clog2(CLKS_PER_BIT). Clears to 0 at every bit boundary and on entry to START.
  - Must not free-run, so bit alignment is relative to frame start.
- busy=1 in every state except IDLE.
- txd is registered, with no combinational path from inputs.

Test Plan:
- CLKS_PER_BIT=4, 8N1; reset low 3 cycles then high; send 0xA5 -> txd low for cycles 1-4 after transfer; data bits 1,0,1,0,0,1,0,1 at 4 cycles each; stop high 4 cycles; frame_done pulses at cycle 40; busy high 40 cycles.
- 8E1: send 0x07 -> parity bit 1. 8O1: send 0x07 -> parity bit 0. 7N2 with DATA_BITS=7: send 0x7F -> frame length 40 cycles, two stop bits high.
- Back-to-back: tx_valid held high with 0x11 then 0x22 -> second word accepted during the first frame; its start bit begins on the cycle immediately after the first frame's last stop cycle; tx_ready low between.
- Backpressure: three words offered continuously -> third is accepted only when the second leaves the buffer; no word is lost or duplicated; the serial stream decodes to 0x11, 0x22, 0x33.
- Mid-frame reset: assert reset during data bit 3 -> txd=1, busy=0, tx_ready=1 after that edge; buffered word dropped; the next transfer produces a clean full frame.
- End-of-frame collision: transfer on the exact frame_done edge with an empty buffer -> exactly one idle cycle (txd=1) before the next start bit.
